uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer that sits directly downstream of the UART Rx frame FSM. It captures each finished frame from the Rx byte bus on the complete/error pulses and stores it with a 1-bit error tag. It presents the stored frames to the host/bus side over a first-word-fall-through valid/ready interface. It also keeps a sticky overrun flag and a saturating frame-error counter, so bytes arriving while the host is slow are never silently lost.

Parameters:
DEPTH, 16, number of entries; power of two, 2..256
ADDR_W, 4, log2(DEPTH); pointer width
STORE_ERR, 1, 1 = error frames are stored with tag set; 0 = error frames are counted only, never stored

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  synchronous, active-high reset
i_rx_d  in  8  received byte from Rx stage; stable while complete/error pulse is high
i_rx_complete  in  1  1-cycle pulse: valid frame, stop bit = 1
i_rx_error  in  1  1-cycle pulse: framing error, stop bit = 0
o_data  out  8  head-entry byte
o_err  out  1  head-entry error tag
o_valid  out  1  head entry present
i_ready  in  1  consumer accepts the head entry when o_valid & i_ready
o_count  out  ADDR_W+1  number of stored entries, 0..DEPTH
o_full  out  1  o_count == DEPTH
o_empty  out  1  o_count == 0
o_overrun  out  1  sticky: a frame was dropped because the FIFO was full
i_clr_overrun  in  1  1-cycle pulse: clears o_overrun
o_err_cnt  out  8  saturating count of i_rx_error pulses

Behaviour:
- Reset (rst=1 at a clk edge) applies in the same edge. Values after reset:
  - rd_ptr=0, wr_ptr=0, o_count=0, o_valid=0, o_empty=1, o_full=0.
  - o_data=8'h00, o_err=0, o_overrun=0, o_err_cnt=0.
  - Memory contents are not cleared; they are don't-care.
- Reset mid-stream discards all entries. A complete/error pulse in the reset cycle is ignored.
- Push request (push_req), evaluated each cycle:
  - push_req = i_rx_complete | (i_rx_error & STORE_ERR).
  - Stored entry = {tag, i_rx_d}; tag = i_rx_error.
  - If complete and error are high in the same cycle, the frame is treated as an error: tag=1, and the error counter increments.
- Pop = o_valid & i_ready.
- Push acceptance:
  - A push is accepted when o_full=0, or when o_full=1 and a pop occurs in the same cycle (pass-through at full).
  - On acceptance: write mem[wr_ptr], then wr_ptr <= wr_ptr+1 modulo DEPTH.
- Pop: rd_ptr <= rd_ptr+1 modulo DEPTH. Pointers wrap naturally at DEPTH-1 -> 0.
- o_count update:
  - +1 on push-only, -1 on pop-only.
  - Unchanged on simultaneous push and pop, or when neither occurs.
  - Never exceeds DEPTH and never underflows.
- Overrun:
  - Occurs when push_req=1, o_full=1 and there is no pop. The new byte is dropped, and stored entries and pointers are unchanged.
  - o_overrun <= 1 at the next edge.
  - o_overrun is cleared only by i_clr_overrun or rst.
  - If i_clr_overrun and a new overrun happen in the same cycle, set wins.
- Error counter:
  - o_err_cnt increments on each i_rx_error pulse, whether or not the frame was stored and whether or not it was dropped.
  - It saturates at 8'hFF and holds.
  - It is cleared only by rst.
- Read side (first-word fall-through):
  - o_data/o_err = head entry, driven from mem[rd_ptr]; o_valid = ~o_empty.
  - When o_valid=0, o_data/o_err are don't-care. The bench checks them only while o_valid=1.
  - Latency: an entry pushed at edge N (FIFO empty before) gives o_valid=1 in the cycle after edge N, with the correct data.
  - A pop at edge M shows the next entry, or o_valid=0, after edge M.
- Pop with o_valid=0 is a no-op.
- Full/empty flags are derived from o_count, so pointers-equal is unambiguous.
- No FSM is needed. All state is pointers, the count, the sticky flag and the counter, each updated in a single synchronous always block group.

Decomposition:
- Shared package uart_pkg holds:
  - UART_DATA_W=8.
  - UART_ENTRY_W=9 ({err, data}).
  - Function clog2 for deriving ADDR_W.
- One sub-module is natural: uart_fifo_core, a generic synchronous FWFT FIFO.
  - Parameters: WIDTH, DEPTH.
  - Ports: push/pop/din/dout/count/full/empty.
- uart_rx_fifo wraps uart_fifo_core and adds:
  - push_req formation,
  - tag formation,
  - overrun logic,
  - the error counter.

Test Plan:
1. Reset, then three complete pulses with bytes 8'h41, 8'h42, 8'h43, i_ready=0 -> o_count=3, o_valid=1, o_data=8'h41, o_err=0. Then i_ready=1 for 3 cycles -> 41, 42, 43 in order, then o_empty=1.
2. STORE_ERR=1: one error pulse with i_rx_d=8'h55 -> entry {1,8'h55}, o_err_cnt=1. STORE_ERR=0, same stimulus -> o_count stays 0, o_err_cnt=1.
3. Fill with 16 bytes 0x00..0x0F, i_ready=0, then a 17th byte 0xAA -> o_full=1, o_count=16, o_overrun=1, head stays 0x00. Drain 16 -> 0x00..0x0F, with no 0xAA.
4. At full, complete pulse (0xBB) in the same cycle as a pop -> o_count stays 16, o_overrun=0, and 0xBB is the last entry read out.
5. Wrap-around: 40 push/pop cycles with random i_ready -> read order equals write order across pointer wrap; o_count never exceeds 16.
6. 300 error pulses -> o_err_cnt=8'hFF. rst asserted mid-stream with 5 entries -> next cycle o_count=0, o_valid=0, o_overrun=0, o_err_cnt=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared widths and helpers for the UART receive buffer
package uart_pkg;
  localparam int UART_DATA_W = 8;
  localparam int UART_ENTRY_W = 9;
  function automatic int clog2(input int n);
    int r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < n) r = i + 1;
    return r;
  endfunction
endpackage

// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: Rx-stage capture, host read and status signals of the receive buffer
interface uart_rx_fifo_if import uart_pkg::*; #(parameter int ADDR_W = 4);
  logic [UART_DATA_W-1:0] i_rx_d;
  logic                   i_rx_complete;
  logic                   i_rx_error;
  logic [UART_DATA_W-1:0] o_data;
  logic                   o_err;
  logic                   o_valid;
  logic                   i_ready;
  logic [ADDR_W:0]        o_count;
  logic                   o_full;
  logic                   o_empty;
  logic                   o_overrun;
  logic                   i_clr_overrun;
  logic [7:0]             o_err_cnt;
  modport master (
    output i_rx_d, i_rx_complete, i_rx_error, i_ready, i_clr_overrun,
    input  o_data, o_err, o_valid, o_count, o_full, o_empty, o_overrun, o_err_cnt
  );
  modport slave (
    input  i_rx_d, i_rx_complete, i_rx_error, i_ready, i_clr_overrun,
    output o_data, o_err, o_valid, o_count, o_full, o_empty, o_overrun, o_err_cnt
  );
endinterface

// File: rtl/uart_fifo_core.sv
// uart_fifo_core: generic synchronous first-word-fall-through FIFO, count-based full/empty
module uart_fifo_core import uart_pkg::*; #(
  parameter int WIDTH = UART_ENTRY_W,
  parameter int DEPTH = 16,
  localparam int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic do_push, do_pop;
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  assign dout = empty ? '0 : mem[rd_ptr];
  // storage write; contents are never cleared
  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= din;
  // pointers wrap naturally at DEPTH; count moves only on push-only or pop-only
  always_ff @(posedge clk)
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: tagged receive byte buffer with sticky overrun and saturating error count
module uart_rx_fifo import uart_pkg::*; #(
  parameter int DEPTH = 16,
  parameter int ADDR_W = clog2(DEPTH),
  parameter int STORE_ERR = 1
) (
  input logic clk,
  input logic rst,
  uart_rx_fifo_if.slave bus
);
  logic [UART_ENTRY_W-1:0] dout;
  logic push_req, pop, full, empty, overrun;
  logic [7:0] err_cnt;
  assign push_req = bus.i_rx_complete | (bus.i_rx_error & (STORE_ERR != 0));
  assign pop = ~empty & bus.i_ready;
  uart_fifo_core #(.WIDTH(UART_ENTRY_W), .DEPTH(DEPTH)) core (
    .clk(clk), .rst(rst), .push(push_req), .pop(pop),
    .din({bus.i_rx_error, bus.i_rx_d}), .dout(dout),
    .count(bus.o_count), .full(full), .empty(empty)
  );
  assign bus.o_data = dout[UART_DATA_W-1:0];
  assign bus.o_err = dout[UART_DATA_W];
  assign bus.o_valid = ~empty;
  assign bus.o_full = full;
  assign bus.o_empty = empty;
  assign bus.o_overrun = overrun;
  assign bus.o_err_cnt = err_cnt;
  // a drop at full without a pop sets the flag, winning over a simultaneous clear
  always_ff @(posedge clk)
    if (rst) overrun <= 1'b0;
    else if (push_req & full & ~pop) overrun <= 1'b1;
    else if (bus.i_clr_overrun) overrun <= 1'b0;
  // every error pulse counts, stored or not, saturating at 8'hFF
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else err_cnt <= err_cnt + 8'(bus.i_rx_error & ~&err_cnt);
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb_uart_rx_fifo: directed and random checks of uart_rx_fifo against a queue model
module tb_uart_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  uart_rx_fifo_if bus ();
  uart_rx_fifo_if bus0 ();
  uart_rx_fifo #(.DEPTH(16), .STORE_ERR(1)) dut (.clk(clk), .rst(rst), .bus(bus));
  uart_rx_fifo #(.DEPTH(16), .STORE_ERR(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  always #5 clk = ~clk;
  int n_chk = 0;
  int n_fail = 0;
  logic [8:0] q[$];
  logic [8:0] q0[$];
  logic ov = 1'b0;
  logic ov0 = 1'b0;
  int ec = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic c, input logic e, input logic [7:0] d, input logic rdy, input logic clr);
    bus.i_rx_complete = c;  bus0.i_rx_complete = c;
    bus.i_rx_error = e;     bus0.i_rx_error = e;
    bus.i_rx_d = d;         bus0.i_rx_d = d;
    bus.i_ready = rdy;      bus0.i_ready = rdy;
    bus.i_clr_overrun = clr; bus0.i_clr_overrun = clr;
  endtask

  task automatic model(input logic c, input logic e, input logic [7:0] d, input logic rdy, input logic clr);
    int sz = q.size();
    int sz0 = q0.size();
    logic pop = rdy && sz > 0;
    logic pop0 = rdy && sz0 > 0;
    logic pr = c | e;
    logic pr0 = c;
    if (pr && sz == 16 && !pop) ov = 1'b1; else if (clr) ov = 1'b0;
    if (pr0 && sz0 == 16 && !pop0) ov0 = 1'b1; else if (clr) ov0 = 1'b0;
    if (pop) void'(q.pop_front());
    if (pop0) void'(q0.pop_front());
    if (pr && (sz < 16 || pop)) q.push_back({e, d});
    if (pr0 && (sz0 < 16 || pop0)) q0.push_back({e, d});
    if (e && ec < 255) ec++;
  endtask

  task automatic check_all();
    chk("count", bus.o_count, q.size());
    chk("valid", bus.o_valid, q.size() != 0);
    chk("full", bus.o_full, q.size() == 16);
    chk("empty", bus.o_empty, q.size() == 0);
    chk("overrun", bus.o_overrun, ov);
    chk("err_cnt", bus.o_err_cnt, ec);
    if (q.size() != 0) begin
      chk("data", bus.o_data, q[0][7:0]);
      chk("err", bus.o_err, q[0][8]);
    end
    chk("count0", bus0.o_count, q0.size());
    chk("valid0", bus0.o_valid, q0.size() != 0);
    chk("overrun0", bus0.o_overrun, ov0);
    chk("err_cnt0", bus0.o_err_cnt, ec);
    if (q0.size() != 0) chk("data0", bus0.o_data, q0[0][7:0]);
  endtask

  task automatic step(input logic c, input logic e, input logic [7:0] d, input logic rdy, input logic clr);
    drive(c, e, d, rdy, clr);
    @(posedge clk);
    model(c, e, d, rdy, clr);
    #1;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_all();
  endtask

  task automatic do_reset(input logic c);
    rst = 1'b1;
    drive(c, 1'b0, 8'h99, 1'b0, 1'b0);
    @(posedge clk);
    q.delete();
    q0.delete();
    ov = 1'b0;
    ov0 = 1'b0;
    ec = 0;
    #1;
    rst = 1'b0;
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    check_all();
  endtask

  initial begin
    drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    do_reset(1'b1);
    chk("rst_data", bus.o_data, 8'h00);
    chk("rst_err", bus.o_err, 1'b0);
    step(1'b1, 1'b0, 8'h41, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h42, 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'h43, 1'b0, 1'b0);
    chk("t1_cnt", bus.o_count, 3);
    chk("t1_head", bus.o_data, 8'h41);
    for (int i = 0; i < 3; i++) begin
      chk("t1_order", bus.o_data, 8'h41 + i);
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t1_empty", bus.o_empty, 1'b1);
    step(1'b0, 1'b1, 8'h55, 1'b0, 1'b0);
    chk("t2_entry", {bus.o_err, bus.o_data}, 9'h155);
    chk("t2_ecnt", bus.o_err_cnt, 1);
    chk("t2_cnt0", bus0.o_count, 0);
    chk("t2_ecnt0", bus0.o_err_cnt, 1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
    step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    chk("t3_full", bus.o_full, 1'b1);
    chk("t3_cnt", bus.o_count, 16);
    chk("t3_ovr", bus.o_overrun, 1'b1);
    chk("t3_head", bus.o_data, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_clr", bus.o_overrun, 1'b0);
    step(1'b1, 1'b0, 8'hBB, 1'b1, 1'b0);
    chk("t4_cnt", bus.o_count, 16);
    chk("t4_ovr", bus.o_overrun, 1'b0);
    for (int i = 0; i < 16; i++) begin
      chk("t4_order", bus.o_data, i == 15 ? 8'hBB : 8'(i + 1));
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    end
    chk("t4_empty", bus.o_empty, 1'b1);
    for (int i = 0; i < 40; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0), 8'($urandom),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) == 0));
      chk("t5_max", bus.o_count <= 16, 1'b1);
    end
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 8'(i), 1'b1, 1'b0);
    chk("t6_sat", bus.o_err_cnt, 8'hFF);
    repeat (17) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("t6_cnt5", bus.o_count, 5);
    do_reset(1'b0);
    chk("t6_rcnt", bus.o_count, 0);
    chk("t6_rvalid", bus.o_valid, 1'b0);
    chk("t6_rovr", bus.o_overrun, 1'b0);
    chk("t6_recnt", bus.o_err_cnt, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
